// File: rtl/ct_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// ct_rd_arbiter_if
// Core-side read bus shared by NREQ cracker cores and the ciphertext read
// arbiter.
//   req_i    : per-core read request, held with addr_i until granted
//   addr_i   : per-core address, core k at [k*ADDR_W +: ADDR_W]
//   gnt_o    : one-hot grant, combinational in the request cycle
//   rvalid_o : one-hot read-data-valid, tagged to the issuing core
//   rdata_o  : shared read data, meaningful only where rvalid_o is set
//   busy_o   : high while any read is in flight
// master = core side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface ct_rd_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req_i;
  logic [NREQ*ADDR_W-1:0] addr_i;
  logic [NREQ-1:0]        gnt_o;
  logic [NREQ-1:0]        rvalid_o;
  logic [DATA_W-1:0]      rdata_o;
  logic                   busy_o;

  modport master (
    output req_i, addr_i,
    input  gnt_o, rvalid_o, rdata_o, busy_o
  );

  modport slave (
    input  req_i, addr_i,
    output gnt_o, rvalid_o, rdata_o, busy_o
  );
endinterface

// File: rtl/ct_rd_arbiter.sv
// -----------------------------------------------------------------------------
// ct_rd_arbiter
// Round-robin read arbiter letting NREQ cracker cores share the single-port
// ciphertext memory. One read is granted per cycle; a tag pipeline of depth
// RD_LAT routes each returning byte back to the core that issued it.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   bus      : core-side request/grant/return bus (slave modport)
//   mem_addr : address to the memory (0 when no read is issued)
//   mem_rden : read strobe to the memory
//   mem_q    : memory read data, valid RD_LAT cycles after mem_rden
// -----------------------------------------------------------------------------
module ct_rd_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  ct_rd_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rden,
  input  logic [DATA_W-1:0]   mem_q
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]         ptr_q, ptr_d;
  tag_t [RD_LAT-1:0]       tag_q, tag_d;
  logic [NREQ-1:0]         rvalid_q, rvalid_d;
  logic [DATA_W-1:0]       rdata_hold_q, rdata_hold_d;

  logic                    win_vld;
  logic [ID_W-1:0]         win_id;
  logic [ID_W-1:0]         scan_idx;
  logic [NREQ-1:0]         gnt;
  logic                    busy;

  // Round-robin scan starting at ptr_q. The wrap is an explicit compare so a
  // non-power-of-2 NREQ never visits an index past the last core.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the tool infers a latch to hold the old value.
    win_vld  = 1'b0;
    win_id   = '0;
    scan_idx = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && bus.req_i[scan_idx]) begin
        win_vld = 1'b1;
        win_id  = scan_idx;
      end
      scan_idx = (scan_idx == LAST_ID) ? '0 : scan_idx + ID_W'(1);
    end
    // Nothing may reach the memory while reset is held.
    if (rst) begin
      win_vld = 1'b0;
      win_id  = '0;
    end
  end

  always_comb begin
    gnt      = '0;
    mem_rden = win_vld;
    mem_addr = '0;
    ptr_d    = ptr_q;
    if (win_vld) begin
      gnt      = NREQ'(1) << win_id;
      mem_addr = bus.addr_i[win_id*ADDR_W +: ADDR_W];
      ptr_d    = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
    end
  end

  // Tag pipeline: a grant enters stage 0; stage RD_LAT-1 lines up with the
  // cycle in which mem_q carries that read's data.
  always_comb begin
    tag_d[0].vld = win_vld;
    tag_d[0].id  = win_id;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // rvalid is registered from the tag about to occupy the last stage, so the
  // pulse sits in exactly the cycle mem_q is valid.
  always_comb begin
    rvalid_d = '0;
    if (tag_d[RD_LAT-1].vld) begin
      rvalid_d = NREQ'(1) << tag_d[RD_LAT-1].id;
    end
  end

  // Data passes straight through from mem_q in the valid cycle and is kept
  // afterwards so rdata_o never shows stale bus noise between reads.
  always_comb begin
    rdata_hold_d = rdata_hold_q;
    if (|rvalid_q) begin
      rdata_hold_d = mem_q;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      busy = busy | tag_q[i].vld;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (rst) begin
      ptr_q        <= '0;
      tag_q        <= '0;
      rvalid_q     <= '0;
      rdata_hold_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      tag_q        <= tag_d;
      rvalid_q     <= rvalid_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = (|rvalid_q) ? mem_q : rdata_hold_q;
  assign bus.busy_o   = busy;

endmodule

// File: tb/tb_ct_rd_arbiter.sv
module tb_ct_rd_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ct_rd_arbiter_if #(.NREQ(2), .ADDR_W(8), .DATA_W(8)) a_if ();
  ct_rd_arbiter_if #(.NREQ(2), .ADDR_W(8), .DATA_W(8)) b_if ();

  logic [7:0] a_maddr, b_maddr;
  logic       a_rden, b_rden;
  logic [7:0] a_q = 8'h00;
  logic [7:0] b_pipe [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] b_q;

  // Instance A: RD_LAT=1 (main checks); instance B: RD_LAT=3 (reset mid-flight).
  ct_rd_arbiter #(.NREQ(2), .ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave),
    .mem_addr(a_maddr), .mem_rden(a_rden), .mem_q(a_q)
  );

  ct_rd_arbiter #(.NREQ(2), .ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave),
    .mem_addr(b_maddr), .mem_rden(b_rden), .mem_q(b_q)
  );

  // Memory models: mem[a] = a ^ 8'h5A with the instance's read latency.
  always @(posedge clk) a_q <= a_maddr ^ 8'h5A;
  always @(posedge clk) begin
    b_pipe[0] <= b_maddr ^ 8'h5A;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_q = b_pipe[2];

  int errors = 0;
  int checks = 0;
  logic [9:0] sb [$];   // {expected one-hot rvalid, expected data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One request cycle on instance A: drive after the edge, check the
  // combinational grant mid-cycle, queue the hand-computed return.
  task automatic drive_a(input logic [1:0] req, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [1:0] exp_gnt, input logic [7:0] exp_addr,
                         input logic [7:0] exp_data, input string name);
    @(posedge clk);
    #1;
    a_if.req_i  = req;
    a_if.addr_i = {a1, a0};
    #2;
    check({name, "_gnt"},  32'(a_if.gnt_o), 32'(exp_gnt));
    check({name, "_addr"}, 32'(a_maddr),    32'(exp_addr));
    check({name, "_rden"}, 32'(a_rden),     32'(|exp_gnt));
    if (exp_gnt != 2'b00) sb.push_back({exp_gnt, exp_data});
  endtask

  // Monitor: every rvalid pulse on A must match the oldest queued expectation.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && a_if.rvalid_o !== 2'b00) begin
        if (sb.size() == 0) begin
          check("unexpected_rvalid", 32'(a_if.rvalid_o), 32'h0);
        end else begin
          e = sb.pop_front();
          check("rv_id",   32'(a_if.rvalid_o), 32'(e[9:8]));
          check("rv_data", 32'(a_if.rdata_o),  32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] req;
    logic [7:0] a0, a1;
    logic [1:0] g;
    logic [7:0] ad, d;
  } vec_t;

  vec_t cont [6] = '{
    '{2'b11, 8'h00, 8'h10, 2'b01, 8'h00, 8'h5A},
    '{2'b11, 8'h01, 8'h10, 2'b10, 8'h10, 8'h4A},
    '{2'b11, 8'h01, 8'h11, 2'b01, 8'h01, 8'h5B},
    '{2'b11, 8'h02, 8'h11, 2'b10, 8'h11, 8'h4B},
    '{2'b11, 8'h02, 8'h12, 2'b01, 8'h02, 8'h58},
    '{2'b11, 8'h03, 8'h12, 2'b10, 8'h12, 8'h48}
  };

  logic [7:0] b2b_exp [8] = '{8'h5A, 8'h5B, 8'h58, 8'h59, 8'h5E, 8'h5F, 8'h5C, 8'h5D};

  initial begin
    int  lat;
    logic found;

    // ---------------- reset, then idle ----------------
    rst         = 1'b1;
    a_if.req_i  = 2'b11;          // requests during reset must not be granted
    a_if.addr_i = 16'h0504;
    b_if.req_i  = 2'b00;
    b_if.addr_i = 16'h0000;
    @(posedge clk);
    #3;
    check("rst_gnt",  32'(a_if.gnt_o), 32'h0);
    check("rst_rden", 32'(a_rden),     32'h0);
    check("rst_addr", 32'(a_maddr),    32'h0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    a_if.req_i = 2'b00;
    #2;
    check("rst_rvalid", 32'(a_if.rvalid_o), 32'h0);
    check("rst_busy",   32'(a_if.busy_o),   32'h0);
    for (int i = 0; i < 3; i++) begin
      drive_a(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, "idle");
      check("idle_rvalid", 32'(a_if.rvalid_o), 32'h0);
      check("idle_busy",   32'(a_if.busy_o),   32'h0);
    end

    // ---------------- single read ----------------
    drive_a(2'b10, 8'h00, 8'h03, 2'b10, 8'h03, 8'h59, "single");
    check("single_busy_t0", 32'(a_if.busy_o), 32'h0);
    drive_a(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, "single_idle");
    check("single_busy_t1",  32'(a_if.busy_o),   32'h1);
    check("single_rvalid",   32'(a_if.rvalid_o), 32'h2);
    check("single_rdata",    32'(a_if.rdata_o),  32'h59);
    drive_a(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, "single_idle");
    check("single_busy_t2",  32'(a_if.busy_o),  32'h0);
    check("single_hold",     32'(a_if.rdata_o), 32'h59);

    // ---------------- contention ----------------
    for (int i = 0; i < 6; i++) begin
      drive_a(cont[i].req, cont[i].a0, cont[i].a1, cont[i].g, cont[i].ad, cont[i].d, "cont");
    end
    drive_a(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, "cont_idle");
    drive_a(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, "cont_idle");

    // ---------------- back-to-back on core 0 ----------------
    for (int i = 0; i < 8; i++) begin
      drive_a(2'b01, 8'(i), 8'h00, 2'b01, 8'(i), b2b_exp[i], "b2b");
      if (i > 0) check("b2b_rv_run", 32'(a_if.rvalid_o), 32'h1);
    end
    drive_a(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, "b2b_idle");
    check("b2b_rv_last", 32'(a_if.rvalid_o), 32'h1);
    drive_a(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, "b2b_idle");
    check("b2b_rv_end", 32'(a_if.rvalid_o), 32'h0);

    // ---------------- withdrawn request ----------------
    // ptr is 1 after the stream; core 1 alone moves it to 0.
    drive_a(2'b10, 8'h00, 8'h20, 2'b10, 8'h20, 8'h7A, "wd_setup");
    drive_a(2'b11, 8'h30, 8'h21, 2'b01, 8'h30, 8'h6A, "wd_lose");
    drive_a(2'b00, 8'h00, 8'h21, 2'b00, 8'h00, 8'h00, "wd_drop");
    drive_a(2'b11, 8'h31, 8'h22, 2'b10, 8'h22, 8'h78, "wd_ptr");
    for (int i = 0; i < 3; i++) begin
      drive_a(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, "wd_idle");
    end
    check("sb_drained", 32'(sb.size()), 32'h0);

    // ---------------- reset mid-flight (instance B, RD_LAT=3) ----------------
    @(posedge clk);
    #1;
    b_if.req_i  = 2'b10;
    b_if.addr_i = {8'h05, 8'h00};
    #2;
    check("mf_gnt", 32'(b_if.gnt_o), 32'h2);
    check("mf_addr", 32'(b_maddr),  32'h05);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      rst         = (i <= 2);
      b_if.req_i  = (i == 1) ? 2'b01 : 2'b00;
      b_if.addr_i = {8'h00, 8'h06};
      #2;
      check("mf_no_rvalid", 32'(b_if.rvalid_o), 32'h0);
      if (i == 1) check("mf_rst_gnt", 32'(b_if.gnt_o), 32'h0);
    end
    @(posedge clk);
    #1;
    b_if.req_i  = 2'b11;
    b_if.addr_i = {8'h07, 8'h06};
    #2;
    check("mf_restart_gnt",  32'(b_if.gnt_o), 32'h1);
    check("mf_restart_addr", 32'(b_maddr),    32'h06);
    lat   = 0;
    found = 1'b0;
    while (!found && lat < 6) begin
      @(posedge clk);
      #1;
      b_if.req_i = 2'b00;
      lat++;
      #2;
      if (b_if.rvalid_o !== 2'b00) begin
        found = 1'b1;
        check("mf_rv_id",   32'(b_if.rvalid_o), 32'h1);
        check("mf_rv_data", 32'(b_if.rdata_o),  32'h5C);
      end
    end
    check("mf_rv_seen", 32'(found), 32'h1);
    check("mf_rv_lat",  32'(lat),   32'h3);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
